regbank_write_arbiter: RTL
==========================

# regbank_write_arbiter

Shares the single register-bank write port among NREQ core-side store controllers in the multicore memory controller. Each requester asks for one fixed-length burst that writes consecutive rows starting at ROW_BASE. The block grants requesters round-robin and sequences the row address and write strobe for each beat. It returns a one-cycle done pulse to the granted requester.

## Interface
- NREQ, 4: number of requesters, 2..8
- DATA_W, 16: row data width
- ROW_BASE, 4'b1000: first row written by every burst
- BURST_LEN, 4: rows per burst, 1..16
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester burst request; level, held until matching done
- wdata_in  in  NREQ*DATA_W  flattened per-requester write data; requester i occupies bits [i*DATA_W +: DATA_W]
- grant  out  NREQ  one-hot registered owner of the write port; zero when idle
- beat  out  $clog2(BURST_LEN) (min 1)  registered beat index within the current burst
- rowaddr  out  4  registered row address to the register bank
- wdata_out  out  DATA_W  combinational mux: wdata_in slice selected by grant; zero when grant==0
- writemem  out  1  registered write strobe to the register bank
- done  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  high in BURST and DONE states

## Operation
- States: IDLE, BURST, DONE.
- IDLE: if any req bit is high, choose a winner round-robin. The search starts at (last+1) mod NREQ. Register grant=onehot(winner), beat=0, rowaddr=ROW_BASE, writemem=1, and go to BURST. If no req bit is high, hold all outputs at their reset values.
- BURST: one bank write per cycle. If beat < BURST_LEN-1, increment beat and rowaddr. If beat == BURST_LEN-1, go to DONE: writemem=0, done[winner]=1, last=winner.
- DONE: clear done, grant, beat and busy; set rowaddr=ROW_BASE; go to IDLE.
- rowaddr arithmetic is 4-bit modulo: ROW_BASE+beat wraps past 4'b1111 to 4'b0000.
- If a requester drops req mid-burst, the burst still completes all BURST_LEN beats and the done pulse is still issued.
- req from non-granted requesters is ignored until the next IDLE decision. Requests arriving while the block is busy are never lost because req is a level signal.
- A requester whose req is still high in the IDLE cycle after its own done is treated as a new request. It competes at the lowest priority.
- Requesters supply data combinationally: they see grant and beat, and drive their wdata_in slice in the same cycle.
- Reset values: grant=0, beat=0, rowaddr=ROW_BASE, writemem=0, done=0, busy=0, state=IDLE, last=NREQ-1, so requester 0 wins first.
- rst asserted mid-burst aborts at the next edge. The aborted burst gets no done pulse and no further writes.

## Timing
- req seen high at edge k in IDLE: writemem is high for cycles k+1 through k+BURST_LEN, done is high for cycle k+BURST_LEN+1, and the block is back in IDLE at cycle k+BURST_LEN+2.
- Back-to-back bursts: minimum 2-cycle gap of writemem=0 (the DONE and IDLE cycles).
- Worst-case grant latency for a requester: (NREQ-1)*(BURST_LEN+2)+1 cycles.
- wdata_out has zero latency from wdata_in, with no register in the path.

## Configuration
- REGBANK_ARB_STATS_EN defined: adds output `grant_cnt` (NREQ*16 bits, flattened). Each 16-bit counter increments in the DONE cycle for its requester and saturates at 16'hFFFF. All counters clear on rst.
- REGBANK_ARB_STATS_EN undefined: the grant_cnt port and its counters are absent. All other behaviour is identical.

## Structure
- Package regbank_arb_pkg holds the state enum (IDLE/BURST/DONE), ROW_BASE_DEFAULT and DATA_W_DEFAULT.
- Sub-module rr_pick: a combinational round-robin picker. Inputs are req and last; outputs are winner index and valid. It is parameterised by NREQ.

## Test plan
- Single request: req=4'b0001 with data 16'hA000+beat. Expect rowaddr 8,9,10,11 with writemem=1 and wdata_out A000..A003, then done[0] for one cycle, then idle.
- All four requesting continuously: grant order 0,1,2,3,0; each burst is 4 writes; writemem gap is exactly 2 cycles between bursts.
- Requester 2 drops req after beat 1: burst still writes rows 8..11 and done[2] pulses.
- rst asserted during beat 2: next cycle writemem=0, grant=0, rowaddr=8, and no done pulse. Next request from requester 0 wins first.
- BURST_LEN=6 with ROW_BASE=4'b1110: rowaddr sequence is E,F,0,1,2,3 and the done pulse follows the 6th write.
- With REGBANK_ARB_STATS_EN defined, after 3 bursts by requester 1, grant_cnt[1]=3 and all other counters are 0.

Source files
------------

// File: rtl/regbank_arb_pkg.sv
// regbank_write_arbiter shared types and defaults.
// State encoding and default geometry for the write-port arbiter.
package regbank_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam logic [3:0] ROW_BASE_DEFAULT = 4'b1000;
    localparam int         DATA_W_DEFAULT   = 16;
    localparam int         CNT_W            = 16;

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Search begins one past the previous winner and wraps.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    // First requester found after last, in circular order
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            logic [IW-1:0] w_idx;
            w_idx = IW'((int'(last) + 1 + i) % NREQ);
            if (!valid && req[w_idx]) begin
                valid  = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: round-robin owner of the register-bank write port.
// Optional per-requester grant counters under `REGBANK_ARB_STATS_EN.
module regbank_write_arbiter
    import regbank_arb_pkg::*;
#(
    parameter  int         NREQ      = 4,
    parameter  int         DATA_W    = DATA_W_DEFAULT,
    parameter  logic [3:0] ROW_BASE  = ROW_BASE_DEFAULT,
    parameter  int         BURST_LEN = 4,
    localparam int         BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] wdata_in,
    output logic [NREQ-1:0]        grant,
    output logic [BW-1:0]          beat,
    output logic [3:0]             rowaddr,
    output logic [DATA_W-1:0]      wdata_out,
    output logic                   writemem,
    output logic [NREQ-1:0]        done,
    output logic                   busy
`ifdef REGBANK_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]  grant_cnt
`endif
);

    localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    arb_state_t      r_state;
    logic [NREQ-1:0] r_grant;
    logic [BW-1:0]   r_beat;
    logic [3:0]      r_rowaddr;
    logic            r_writemem;
    logic [NREQ-1:0] r_done;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_winner;

    arb_state_t      w_state_nxt;
    logic [NREQ-1:0] w_grant_nxt;
    logic [BW-1:0]   w_beat_nxt;
    logic [3:0]      w_rowaddr_nxt;
    logic            w_writemem_nxt;
    logic [NREQ-1:0] w_done_nxt;
    logic [IW-1:0]   w_last_nxt;
    logic [IW-1:0]   w_winner_nxt;

    logic [IW-1:0]     w_pick;
    logic              w_pick_vld;
    logic [NREQ-1:0]   w_pick_oh;
    logic [DATA_W-1:0] w_wdata;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req),
        .last   (r_last),
        .winner (w_pick),
        .valid  (w_pick_vld)
    );

    assign w_pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;

    // State and output registers; reset aborts any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_beat     <= '0;
            r_rowaddr  <= ROW_BASE;
            r_writemem <= 1'b0;
            r_done     <= '0;
            r_last     <= IW'(NREQ - 1);
            r_winner   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_beat     <= w_beat_nxt;
            r_rowaddr  <= w_rowaddr_nxt;
            r_writemem <= w_writemem_nxt;
            r_done     <= w_done_nxt;
            r_last     <= w_last_nxt;
            r_winner   <= w_winner_nxt;
        end
    end

    // Next-state and next-output decisions for IDLE/BURST/DONE
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_beat_nxt     = r_beat;
        w_rowaddr_nxt  = r_rowaddr;
        w_writemem_nxt = r_writemem;
        w_done_nxt     = r_done;
        w_last_nxt     = r_last;
        w_winner_nxt   = r_winner;
        unique case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nxt    = w_pick_oh;
                    w_beat_nxt     = '0;
                    w_rowaddr_nxt  = ROW_BASE;
                    w_writemem_nxt = 1'b1;
                    w_winner_nxt   = w_pick;
                    w_state_nxt    = BURST;
                end
            end
            BURST: begin
                if (r_beat != LAST_BEAT) begin
                    w_beat_nxt    = r_beat + BW'(1);
                    w_rowaddr_nxt = r_rowaddr + 4'd1;
                end else begin
                    w_writemem_nxt = 1'b0;
                    w_done_nxt     = r_grant;
                    w_last_nxt     = r_winner;
                    w_state_nxt    = DONE;
                end
            end
            DONE: begin
                w_done_nxt    = '0;
                w_grant_nxt   = '0;
                w_beat_nxt    = '0;
                w_rowaddr_nxt = ROW_BASE;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // One-hot grant makes an OR-mux sufficient; zero when idle
    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_wdata = w_wdata | wdata_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant     = r_grant;
    assign beat      = r_beat;
    assign rowaddr   = r_rowaddr;
    assign writemem  = r_writemem;
    assign done      = r_done;
    assign busy      = (r_state != IDLE);
    assign wdata_out = w_wdata;

`ifdef REGBANK_ARB_STATS_EN
    logic [NREQ*CNT_W-1:0] r_cnt;

    // Saturating per-requester count of completed bursts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == DONE) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_grant[i] && (r_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    r_cnt[i*CNT_W +: CNT_W] <= r_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign grant_cnt = r_cnt;
`endif

endmodule
